// File: rtl/frame_deserializer.sv
// Rebuilds two W-bit words and a 3-bit mode from the nibble-framed byte stream.
// Detects short frames and mid-frame mode changes; counts good frames.
module frame_deserializer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  output logic         busy,
  output logic [W-1:0] word_a,
  output logic [W-1:0] word_b,
  output logic [2:0]   mode_out,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic [15:0]  frame_cnt
);

  // state  | meaning
  // IDLE   | waiting for the first valid byte of a frame
  // RECV_A | assembling word A
  // RECV_B | assembling word B
  // DRAIN  | mode change seen; ignore bytes until a gap
  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B, DRAIN} state_t;

  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [W-1:0]   hold_a_q, hold_a_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     fmode_q, fmode_d;
  logic [W-1:0]   word_a_q, word_a_d;
  logic [W-1:0]   word_b_q, word_b_d;
  logic [2:0]     mode_q, mode_d;
  logic           fv_q, fv_d;
  logic           fe_q, fe_d;
  logic [1:0]     ec_q, ec_d;
  logic [15:0]    fcnt_q, fcnt_d;

  logic           rdy;
  logic [2:0]     bmode;
  logic [3:0]     nib;
  logic [W-1:0]   shifted;
  logic           last_nib;

  assign rdy      = in_byte[4];
  assign bmode    = in_byte[7:5];
  assign nib      = in_byte[3:0];
  assign shifted  = {sr_q[W-5:0], nib};
  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    hold_a_d = hold_a_q;
    cnt_d    = cnt_q;
    fmode_d  = fmode_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    mode_d   = mode_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    ec_d     = ec_q;
    fcnt_d   = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (rdy) begin
          fmode_d = bmode;
          sr_d    = W'(nib);
          cnt_d   = CW'(1);
          state_d = RECV_A;
        end
      end
      RECV_A, RECV_B: begin
        if (!rdy) begin
          fe_d    = 1'b1;
          ec_d    = 2'b01;
          state_d = IDLE;
        end else if (bmode != fmode_q) begin
          fe_d    = 1'b1;
          ec_d    = 2'b10;
          state_d = DRAIN;
        end else begin
          sr_d = shifted;
          if (!last_nib) begin
            cnt_d = cnt_q + CW'(1);
          end else if (state_q == RECV_A) begin
            hold_a_d = shifted;
            cnt_d    = '0;
            state_d  = RECV_B;
          end else begin
            word_a_d = hold_a_q;
            word_b_d = shifted;
            mode_d   = fmode_q;
            fv_d     = 1'b1;
            fcnt_d   = fcnt_q + 16'd1;
            state_d  = IDLE;
          end
        end
      end
      DRAIN: begin
        // a gap is the only safe resync point after a mode change
        if (!rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      hold_a_q <= '0;
      cnt_q    <= '0;
      fmode_q  <= '0;
      word_a_q <= '0;
      word_b_q <= '0;
      mode_q   <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
      ec_q     <= 2'b00;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      hold_a_q <= hold_a_d;
      cnt_q    <= cnt_d;
      fmode_q  <= fmode_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      mode_q   <= mode_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
      ec_q     <= ec_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign busy        = (state_q == RECV_A) || (state_q == RECV_B);
  assign word_a      = word_a_q;
  assign word_b      = word_b_q;
  assign mode_out    = mode_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_code    = ec_q;
  assign frame_cnt   = fcnt_q;

endmodule
